// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one data memory between NCORES cores. Cores raise read/write
//   requests; the arbiter grants one core at a time in round-robin order.
//   It drives the memory port for MEMLAT cycles and then pulses done to the
//   served core together with the read data. Every other requesting core
//   sees stall so that its microsequencer holds state.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_rd/req_wr     per-core read/write request (write wins if both set)
//   req_addr          per-core address, core i at [i*AW +: AW]
//   req_wdata         per-core write data, same packing
//   done              one-cycle completion pulse to the served core
//   stall             pending request not completing this cycle
//   rdata             read data, valid while the matching done bit is high
//   mem_addr/mem_wdata/mem_rd/mem_wr   shared memory port
//   mem_rdata         memory read data, valid in the last access cycle
module mem_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int MEMLAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_rd,
  input  logic [NCORES-1:0]    req_wr,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  output logic [NCORES-1:0]    done,
  output logic [NCORES-1:0]    stall,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int LW = (MEMLAT > 1) ? $clog2(MEMLAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr, rr_ptr_n;
  logic [PW-1:0]     owner, owner_n;
  logic [LW-1:0]     lat_cnt, lat_cnt_n;
  logic [NCORES-1:0] done_n;
  logic [DW-1:0]     rdata_n;
  logic [AW-1:0]     mem_addr_n;
  logic [DW-1:0]     mem_wdata_n;
  logic              mem_rd_n, mem_wr_n;

  logic [NCORES-1:0] pending;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     grant_idx;
  logic              grant_found;

  assign pending = req_rd | req_wr;
  // done is registered, so a core is released from stall exactly in its done cycle.
  assign stall   = pending & ~done;

  // First pending core at or after rr_ptr, wrapping modulo NCORES.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NCORES; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NCORES);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    lat_cnt_n   = lat_cnt;
    done_n      = '0;
    rdata_n     = rdata;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rd_n    = mem_rd;
    mem_wr_n    = mem_wr;
    case (state)
      IDLE: begin
        if (grant_found) begin
          // Operation, address and data are latched here, so later changes
          // on the owner's request lines have no effect on this access.
          owner_n     = grant_idx;
          mem_addr_n  = req_addr[int'(grant_idx)*AW +: AW];
          mem_wdata_n = req_wdata[int'(grant_idx)*DW +: DW];
          mem_wr_n    = req_wr[grant_idx];
          mem_rd_n    = req_rd[grant_idx] & ~req_wr[grant_idx];
          rr_ptr_n    = PW'((int'(grant_idx) + 1) % NCORES);
          lat_cnt_n   = LW'(MEMLAT - 1);
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt == '0) begin
          if (mem_rd) rdata_n = mem_rdata;
          mem_rd_n      = 1'b0;
          mem_wr_n      = 1'b0;
          done_n[owner] = 1'b1;
          state_n       = DONE;
        end else begin
          lat_cnt_n = lat_cnt - LW'(1);
        end
      end
      DONE: begin
        // The IDLE cycle that follows re-arbitrates among fresh requests.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lat_cnt   <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      lat_cnt   <= lat_cnt_n;
      done      <= done_n;
      rdata     <= rdata_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_rd    <= mem_rd_n;
      mem_wr    <= mem_wr_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (NCORES=4, AW=DW=16, MEMLAT=2).
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge, half a cycle after the rising edge that updated them.
module tb_mem_arbiter;

  localparam int NCORES = 4;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int MEMLAT = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCORES-1:0]    req_rd = '0;
  logic [NCORES-1:0]    req_wr = '0;
  logic [NCORES*AW-1:0] req_addr;
  logic [NCORES*DW-1:0] req_wdata;
  logic [NCORES-1:0]    done;
  logic [NCORES-1:0]    stall;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [DW-1:0]        mem_rdata = '0;

  logic [AW-1:0] atab [NCORES];
  logic [DW-1:0] wtab [NCORES];

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      req_addr[i*AW +: AW]  = atab[i];
      req_wdata[i*DW +: DW] = wtab[i];
    end
  end

  mem_arbiter #(
    .NCORES(NCORES), .AW(AW), .DW(DW), .MEMLAT(MEMLAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .stall(stall), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    atab[c]   = a;
    wtab[c]   = wd;
    req_rd[c] = rd;
    req_wr[c] = wr;
  endtask

  // Entered on the falling edge of an IDLE cycle with requests already driven;
  // expects core c to be granted at the next rising edge. others = the other
  // cores pending during the grant. Returns on the falling edge of the next IDLE cycle.
  task automatic serve(input int c, input logic rd, input logic wr, input logic [3:0] others);
    logic [3:0] me;
    me = 4'(1 << c);
    for (int k = 0; k < MEMLAT; k++) begin
      @(negedge clk);
      check("mem_addr", 32'(mem_addr), 32'(atab[c]));
      check("mem_rd", 32'(mem_rd), 32'(rd));
      check("mem_wr", 32'(mem_wr), 32'(wr));
      if (wr) check("mem_wdata", 32'(mem_wdata), 32'(wtab[c]));
      check("done_busy", 32'(done), 32'(0));
      check("stall_busy", 32'(stall), 32'(others | me));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(me));
    check("stall_done", 32'(stall), 32'(others));
    check("strobes_off", 32'({mem_rd, mem_wr}), 32'(0));
    req_rd[c] = 1'b0;
    req_wr[c] = 1'b0;
    @(negedge clk);
    check("done_clear", 32'(done), 32'(0));
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NCORES; i++) begin
      atab[i] = '0;
      wtab[i] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'(0));
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst_strobes", 32'({mem_rd, mem_wr}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // reset in the middle of an access
    set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    mem_rdata = 16'h7777;
    @(negedge clk);
    check("mid_rd", 32'(mem_rd), 32'(1));
    check("mid_addr", 32'(mem_addr), 32'(16'h0100));
    #2;
    rst = 1'b1;
    req_rd[0] = 1'b0;
    #1;
    check("arst_strobes", 32'({mem_rd, mem_wr}), 32'(0));
    check("arst_addr", 32'(mem_addr), 32'(0));
    check("arst_done", 32'(done), 32'(0));
    check("arst_stall", 32'(stall), 32'(0));
    check("arst_rdata", 32'(rdata), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'(0));
      check("post_rst_rd", 32'(mem_rd), 32'(0));
    end

    // first request after reset: core2 read
    set_req(2, 1'b1, 1'b0, 16'h0200, 16'h0000);
    mem_rdata = 16'h5A5A;
    #1 check("stall_req2", 32'(stall), 32'(4'b0100));
    serve(2, 1'b1, 1'b0, 4'b0000);
    check("rdata_c2", 32'(rdata), 32'(16'h5A5A));

    // single read core1
    set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    mem_rdata = 16'hBEEF;
    #1 check("stall_req1", 32'(stall), 32'(4'b0010));
    serve(1, 1'b1, 1'b0, 4'b0000);
    check("rdata_c1", 32'(rdata), 32'(16'hBEEF));

    // single write core3: rdata must hold
    set_req(3, 1'b0, 1'b1, 16'h0012, 16'h1234);
    mem_rdata = 16'hDEAD;
    serve(3, 1'b0, 1'b1, 4'b0000);
    check("rdata_after_wr", 32'(rdata), 32'(16'hBEEF));

    // read and write together from core2 -> write
    set_req(2, 1'b1, 1'b1, 16'h0077, 16'h5555);
    serve(2, 1'b0, 1'b1, 4'b0000);
    check("rdata_after_rdwr", 32'(rdata), 32'(16'hBEEF));

    // rr_ptr is 3: cores 1 and 3 pending -> 3 first, then 1
    set_req(1, 1'b1, 1'b0, 16'h0111, 16'h0000);
    set_req(3, 1'b1, 1'b0, 16'h0333, 16'h0000);
    mem_rdata = 16'h3333;
    serve(3, 1'b1, 1'b0, 4'b0010);
    check("rdata_wrap3", 32'(rdata), 32'(16'h3333));
    mem_rdata = 16'h1111;
    serve(1, 1'b1, 1'b0, 4'b0000);
    check("rdata_wrap1", 32'(rdata), 32'(16'h1111));

    // rr_ptr should now be 2: cores 1 and 2 pending -> 2 first
    set_req(1, 1'b1, 1'b0, 16'h0101, 16'h0000);
    set_req(2, 1'b1, 1'b0, 16'h0202, 16'h0000);
    serve(2, 1'b1, 1'b0, 4'b0010);
    serve(1, 1'b1, 1'b0, 4'b0000);

    // core3 alone moves rr_ptr back to 0
    set_req(3, 1'b1, 1'b0, 16'h0303, 16'h0000);
    serve(3, 1'b1, 1'b0, 4'b0000);

    // four-way contention, each core re-requests after its done
    for (int i = 0; i < NCORES; i++) set_req(i, 1'b1, 1'b0, 16'(16'h1000 + i), 16'h0000);
    for (int g = 0; g < 5; g++) begin
      serve(order[g], 1'b1, 1'b0, 4'(4'hF & ~(1 << order[g])));
      if (g < 4) req_rd[order[g]] = 1'b1;
    end
    req_rd = '0;
    req_wr = '0;
    repeat (2) @(negedge clk);
    check("end_done", 32'(done), 32'(0));
    check("end_stall", 32'(stall), 32'(0));
    check("end_strobes", 32'({mem_rd, mem_wr}), 32'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
